// File: rtl/camera_frame_capture.sv
// OV7670 capture front end: packs RGB565 byte pairs into RGB332 pixels and
// issues one linear-address buffer write per kept pixel, clipped to WIDTH x HEIGHT.
module camera_frame_capture #(
   parameter int WIDTH  = 176,
   parameter int HEIGHT = 144,
   parameter int ADDR_W = 15
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [7:0]        CAM_DATA,
   input  logic              CAM_HREF,
   input  logic              CAM_VSYNC,
   output logic [7:0]        PIXEL_OUT,
   output logic [ADDR_W-1:0] WRITE_ADDR,
   output logic              WRITE_EN,
   output logic [8:0]        X_ADDR,
   output logic [8:0]        Y_ADDR,
   output logic              FRAME_DONE,
   output logic              ODD_BYTE_ERR
);

   localparam logic [8:0]  X_MAX   = 9'(WIDTH);
   localparam logic [8:0]  Y_MAX   = 9'(HEIGHT);
   localparam logic [31:0] WIDTH_U = 32'(WIDTH);

   typedef enum logic [1:0] {
      WAIT_FRAME,
      LINE_IDLE,
      BYTE_HI,
      BYTE_LO
   } state_t;

   state_t            state_q, state_d;
   logic [8:0]        x_q, x_d;
   logic [8:0]        y_q, y_d;
   logic [7:0]        hi_q, hi_d;
   logic [7:0]        pix_q, pix_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic              fd_q, fd_d;
   logic              odd_q, odd_d;
   logic              vsync_prev_q;
   logic              eol;

   function automatic logic [7:0] rgb565_to_332(input logic [7:0] hi, input logic [7:0] lo);
      return {hi[7:5], hi[2:0], lo[4:3]};
   endfunction

   function automatic logic [ADDR_W-1:0] lin_addr(input logic [8:0] y, input logic [8:0] x);
      return ADDR_W'(32'(y) * WIDTH_U + 32'(x));
   endfunction

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q      <= WAIT_FRAME;
         x_q          <= '0;
         y_q          <= '0;
         hi_q         <= '0;
         pix_q        <= '0;
         addr_q       <= '0;
         we_q         <= 1'b0;
         fd_q         <= 1'b0;
         odd_q        <= 1'b0;
         vsync_prev_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         hi_q         <= hi_d;
         pix_q        <= pix_d;
         addr_q       <= addr_d;
         we_q         <= we_d;
         fd_q         <= fd_d;
         odd_q        <= odd_d;
         vsync_prev_q <= CAM_VSYNC;
      end
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      hi_d    = hi_q;
      pix_d   = pix_q;
      addr_d  = addr_q;
      we_d    = 1'b0;
      fd_d    = 1'b0;
      odd_d   = 1'b0;
      eol     = 1'b0;

      // Column advances while the write strobe is out, so the strobe sees pre-increment X.
      if (we_q && (x_q < X_MAX)) begin
         x_d = x_q + 9'd1;
      end

      if (state_q == WAIT_FRAME) begin
         if (vsync_prev_q && !CAM_VSYNC) begin
            state_d = LINE_IDLE;
         end
      end else if (CAM_VSYNC) begin
         // Blanking overrides any line activity; a half pixel is silently dropped.
         state_d = WAIT_FRAME;
         x_d     = '0;
         y_d     = '0;
         hi_d    = '0;
         fd_d    = !vsync_prev_q;
      end else begin
         case (state_q)
            LINE_IDLE: begin
               if (CAM_HREF) begin
                  hi_d    = CAM_DATA;
                  state_d = BYTE_LO;
               end
            end
            BYTE_LO: begin
               if (CAM_HREF) begin
                  pix_d   = rgb565_to_332(hi_q, CAM_DATA);
                  addr_d  = lin_addr(y_q, x_q);
                  we_d    = (x_q < X_MAX) && (y_q < Y_MAX);
                  state_d = BYTE_HI;
               end else begin
                  odd_d = 1'b1;
                  eol   = 1'b1;
               end
            end
            BYTE_HI: begin
               if (CAM_HREF) begin
                  hi_d    = CAM_DATA;
                  state_d = BYTE_LO;
               end else begin
                  eol = 1'b1;
               end
            end
            default: begin
               state_d = WAIT_FRAME;
            end
         endcase

         if (eol) begin
            x_d     = '0;
            y_d     = (y_q < Y_MAX) ? y_q + 9'd1 : y_q;
            state_d = LINE_IDLE;
         end
      end
   end

   assign PIXEL_OUT    = pix_q;
   assign WRITE_ADDR   = addr_q;
   assign WRITE_EN     = we_q;
   assign X_ADDR       = x_q;
   assign Y_ADDR       = y_q;
   assign FRAME_DONE   = fd_q;
   assign ODD_BYTE_ERR = odd_q;

endmodule
